// File: rtl/cpu_pkg.sv
//------------------------------------------------------------------------------
// Module : cpu_pkg
// Brief  : Shared CPU types and default sizes for the register file slice.
// Rev    : 1.0  initial multi-port register file release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

    localparam int CPU_DATA_W  = 32;
    localparam int CPU_REG_NUM = 32;

    typedef logic                           bit_t;
    typedef logic [CPU_DATA_W-1:0]          word_t;
    typedef logic [$clog2(CPU_REG_NUM)-1:0] regaddr_t;

endpackage

`default_nettype wire

// File: rtl/regfile_sb.sv
//------------------------------------------------------------------------------
// Module : regfile_sb
// Brief  : Per-register busy scoreboard with flush/clear/set precedence.
// Rev    : 1.0  initial multi-port register file release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_sb
    import cpu_pkg::*;
#(
    parameter int REG_NUM  = CPU_REG_NUM,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(REG_NUM)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_WR-1:0]              we,
    input  logic [NUM_WR-1:0][AW-1:0]      waddr,
    input  logic                           rsv_en,
    input  logic [AW-1:0]                  rsv_addr,
    input  logic                           flush,
    input  logic [NUM_RD-1:0][AW-1:0]      raddr,
    input  logic [NUM_RD-1:0]              rd_hit,
    output logic [NUM_RD-1:0]              rbusy
);

    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;
    bit_t               w_rsv_ok;

    assign w_rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

    // The set is applied after the clears so a new producer supersedes writeback.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (we[p]) begin
                    busy_d[waddr[p]] = 1'b0;
                end
            end
            if (w_rsv_ok) begin
                busy_d[rsv_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rbusy = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            rbusy[r] = busy_q[raddr[r]] && !rd_hit[r]
                       && !((ZERO_REG != 0) && (raddr[r] == '0));
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
//------------------------------------------------------------------------------
// Module : regfile_mp
// Brief  : Multi-port GPR file with prioritised writes, bypass and scoreboard.
// Rev    : 1.0  initial multi-port register file release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_mp
    import cpu_pkg::*;
#(
    parameter int DATA_W   = CPU_DATA_W,
    parameter int REG_NUM  = CPU_REG_NUM,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(REG_NUM)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_WR-1:0]              we,
    input  logic [NUM_WR-1:0][AW-1:0]      waddr,
    input  logic [NUM_WR-1:0][DATA_W-1:0]  wdata,
    input  logic [NUM_RD-1:0][AW-1:0]      raddr,
    output logic [NUM_RD-1:0][DATA_W-1:0]  rdata,
    output logic [NUM_RD-1:0]              rbusy,
    input  logic                           rsv_en,
    input  logic [AW-1:0]                  rsv_addr,
    input  logic                           flush
);

    logic [REG_NUM-1:0][DATA_W-1:0] regs_q;
    logic [REG_NUM-1:0][DATA_W-1:0] regs_d;
    logic [NUM_RD-1:0]              w_rd_hit;

    // Ascending port order lets the highest enabled port win on a shared address.
    always_comb begin
        regs_d = regs_q;
        for (int p = 0; p < NUM_WR; p++) begin
            if (we[p] && !((ZERO_REG != 0) && (waddr[p] == '0))) begin
                regs_d[waddr[p]] = wdata[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        bit_t              w_hit;
        logic [DATA_W-1:0] w_byp;

        always_comb begin
            w_hit = 1'b0;
            w_byp = '0;
            for (int p = 0; p < NUM_WR; p++) begin
                if (we[p] && (waddr[p] == raddr[r])) begin
                    w_hit = 1'b1;
                    w_byp = wdata[p];
                end
            end
        end

        assign w_rd_hit[r] = w_hit;
        assign rdata[r]    = ((ZERO_REG != 0) && (raddr[r] == '0)) ? '0 :
                             w_hit ? w_byp : regs_q[raddr[r]];
    end

    regfile_sb #(
        .REG_NUM  (REG_NUM),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (waddr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .flush    (flush),
        .raddr    (raddr),
        .rd_hit   (w_rd_hit),
        .rbusy    (rbusy)
    );

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
//------------------------------------------------------------------------------
// Module : tb_regfile_mp
// Brief  : Self-checking bench for regfile_mp (2 read, 2 write, zero register).
// Rev    : 1.0  initial multi-port register file release
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_mp;

    typedef struct packed {
        logic             rst;
        logic [1:0]       we;
        logic [1:0][4:0]  wa;
        logic [1:0][31:0] wd;
        logic [1:0][4:0]  ra;
        logic             rsv;
        logic [4:0]       rsa;
        logic             fl;
        logic             chk;
        logic [31:0]      e0;
        logic [31:0]      e1;
        logic [1:0]       eb;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       we;
    logic [1:0][4:0]  waddr;
    logic [1:0][31:0] wdata;
    logic [1:0][4:0]  raddr;
    logic [1:0][31:0] rdata;
    logic [1:0]       rbusy;
    logic             rsv_en;
    logic [4:0]       rsv_addr;
    logic             flush;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_reg  [32];
    logic        m_busy [32];
    vec_t        tbl[$];

    always #5 clk = ~clk;

    regfile_mp #(
        .DATA_W   (32),
        .REG_NUM  (32),
        .NUM_RD   (2),
        .NUM_WR   (2),
        .ZERO_REG (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr    (raddr),
        .rdata    (rdata),
        .rbusy    (rbusy),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .flush    (flush)
    );

    function automatic vec_t mk(logic r, logic [1:0] w, logic [4:0] a0, logic [31:0] d0,
                                logic [4:0] a1, logic [31:0] d1, logic [4:0] r0, logic [4:0] r1,
                                logic rs, logic [4:0] rsa, logic fl, logic chk,
                                logic [31:0] e0, logic [31:0] e1, logic [1:0] eb);
        vec_t v;
        v.rst = r;  v.we = w;
        v.wa[0] = a0; v.wd[0] = d0; v.wa[1] = a1; v.wd[1] = d1;
        v.ra[0] = r0; v.ra[1] = r1;
        v.rsv = rs; v.rsa = rsa; v.fl = fl;
        v.chk = chk; v.e0 = e0; v.e1 = e1; v.eb = eb;
        return v;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t v = '0;
        v.rst = ($urandom_range(0, 63) == 0);
        v.we  = 2'($urandom);
        for (int p = 0; p < 2; p++) begin
            v.wa[p] = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            v.wd[p] = $urandom;
            v.ra[p] = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
        end
        v.rsv = ($urandom_range(0, 2) == 0);
        v.rsa = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
        v.fl  = ($urandom_range(0, 15) == 0);
        return v;
    endfunction

    // Reference: what a reader sees this cycle, from architectural state plus bypass.
    function automatic logic [31:0] m_read(vec_t v, int r);
        logic [31:0] val;
        if (v.ra[r] == 5'd0) return 32'd0;
        val = m_reg[v.ra[r]];
        for (int p = 0; p < 2; p++)
            if (v.we[p] && v.wa[p] == v.ra[r]) val = v.wd[p];
        return val;
    endfunction

    function automatic logic m_rbusy(vec_t v, int r);
        if (v.ra[r] == 5'd0) return 1'b0;
        for (int p = 0; p < 2; p++)
            if (v.we[p] && v.wa[p] == v.ra[r]) return 1'b0;
        return m_busy[v.ra[r]];
    endfunction

    function automatic void m_update(vec_t v);
        if (v.rst) begin
            for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_busy[i] = 1'b0; end
            return;
        end
        for (int p = 0; p < 2; p++)
            if (v.we[p] && v.wa[p] != 5'd0) m_reg[v.wa[p]] = v.wd[p];
        if (v.fl) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else begin
            for (int p = 0; p < 2; p++)
                if (v.we[p]) m_busy[v.wa[p]] = 1'b0;
            if (v.rsv && v.rsa != 5'd0) m_busy[v.rsa] = 1'b1;
        end
    endfunction

    task automatic drive(vec_t v);
        rst = v.rst; we = v.we; waddr = v.wa; wdata = v.wd; raddr = v.ra;
        rsv_en = v.rsv; rsv_addr = v.rsa; flush = v.fl;
    endtask

    task automatic check(string nm, int idx, logic [31:0] e0, logic [31:0] e1, logic [1:0] eb);
        total++;
        if (rdata[0] !== e0 || rdata[1] !== e1 || rbusy !== eb) begin
            bad++;
            $display("FAIL %s #%0d: rdata=%h/%h rbusy=%b, expected %h/%h rbusy=%b",
                     nm, idx, rdata[0], rdata[1], rbusy, e0, e1, eb);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_busy[i] = 1'b0; end

        // Reset and sweep every register on both ports.
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 32; i++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i), 0, 0, 0, 1, 0, 0, 0));
        // Write r5, bypass then stored.
        tbl.push_back(mk(0, 2'b01, 5, 32'hDEADBEEF, 0, 0, 5, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 5, 6, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0));
        // Two ports on r7: port 1 wins.
        tbl.push_back(mk(0, 2'b11, 7, 32'h11111111, 7, 32'h22222222, 7, 5, 0, 0, 0, 1,
                         32'h22222222, 32'hDEADBEEF, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 7, 5, 0, 0, 0, 1, 32'h22222222, 32'hDEADBEEF, 0));
        // Register 0 ignores writes and reservations.
        tbl.push_back(mk(0, 2'b11, 0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        // Reserve r3, then write it back at t+3.
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0, 1, 3, 0, 1, 0, 0, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0, 2'b01));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0, 2'b01));
        tbl.push_back(mk(0, 2'b01, 3, 32'h5, 0, 0, 3, 0, 0, 0, 0, 1, 32'h5, 0, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 1, 32'h5, 0, 2'b00));
        // Reserve and write r9 together: set wins.
        tbl.push_back(mk(0, 2'b01, 9, 32'hA, 0, 0, 9, 0, 1, 9, 0, 1, 32'hA, 0, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 0, 1, 32'hA, 0, 2'b01));
        // Reserve r4, r6, then flush with a discarded reserve of r8.
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4, 6, 1, 4, 0, 1, 0, 0, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4, 6, 1, 6, 0, 1, 0, 0, 2'b01));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4, 6, 1, 8, 1, 1, 0, 0, 2'b11));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8, 4, 0, 0, 0, 1, 0, 0, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 6, 9, 0, 0, 0, 1, 0, 32'hA, 2'b00));
        // Write r10, then reset overriding a write and a reserve.
        tbl.push_back(mk(0, 2'b01, 10, 32'h3, 0, 0, 10, 0, 0, 0, 0, 1, 32'h3, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 10, 5, 0, 0, 0, 1, 32'h3, 32'hDEADBEEF, 0));
        tbl.push_back(mk(1, 2'b01, 11, 32'h7, 0, 0, 10, 11, 1, 12, 0, 1, 32'h3, 32'h7, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 10, 11, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 12, 5, 0, 0, 0, 1, 0, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i]);
            #1;
            if (tbl[i].chk) check("directed", i, tbl[i].e0, tbl[i].e1, tbl[i].eb);
            @(posedge clk);
            m_update(tbl[i]);
            #1;
        end

        for (int i = 0; i < 400; i++) begin
            vec_t v;
            v = rnd_vec();
            drive(v);
            #1;
            check("random", i, m_read(v, 0), m_read(v, 1), {m_rbusy(v, 1), m_rbusy(v, 0)});
            @(posedge clk);
            m_update(v);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file, successor to the single-write/dual-read GPR file.
- Sits between decode/issue (read, reserve) and writeback (write) in the CPU pipeline.
- Adds N write ports with priority, N read ports with full write-to-read bypass, a hardwired-zero register option, and a per-register busy scoreboard with flush.
- Issue logic uses the scoreboard to detect RAW hazards.

Parameters:
- DATA_W, 32, register width in bits
- REG_NUM, 32, number of architectural registers (power of 2, >=2)
- NUM_RD, 2, number of read ports (>=1)
- NUM_WR, 1, number of write ports (>=1)
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and busy sets; 0 = register 0 is ordinary

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- we  in  NUM_WR  per-port write enable
- waddr  in  NUM_WR x AW  write addresses, AW = $clog2(REG_NUM)
- wdata  in  NUM_WR x DATA_W  write data
- raddr  in  NUM_RD x AW  read addresses
- rdata  out  NUM_RD x DATA_W  read data (combinational)
- rbusy  out  NUM_RD  1 = read register has an outstanding producer
- rsv_en  in  1  reserve (set busy) for destination register
- rsv_addr  in  AW  register to reserve
- flush  in  1  clear all busy bits (pipeline squash)

Behaviour:
- Reset: on the rst clock edge all registers become 0 and all busy bits become 0. rst overrides every write, reserve and flush in that cycle. Outputs are combinational; with rst held they reflect the zeroed state from the first edge onward.
- Write: at posedge clk, for each port p with we[p]=1, reg[waddr[p]] <= wdata[p]. One-cycle write latency to storage.
- Write conflict: when several enabled ports target the same address, the highest port index wins, both for storage and for bypass.
- Register 0 with ZERO_REG=1:
  - Writes are dropped.
  - rdata returns 0 regardless of bypass.
  - rbusy returns 0.
  - rsv_en to address 0 is ignored.
- Read: rdata[r] is fully combinational from raddr[r].
  - If any enabled write port matches raddr[r] this cycle, return the winning port's wdata (same-cycle bypass).
  - Otherwise return the stored value.
- Busy scoreboard, one bit per register, updated at posedge clk in this precedence:
  1. flush=1: all bits <= 0; a same-cycle rsv_en is discarded.
  2. Else: any enabled write to address a clears busy[a].
  3. Then rsv_en sets busy[rsv_addr]. When a reservation and a write hit the same address in one cycle, the set wins (the new producer supersedes the one writing back).
- rbusy[r]: reflects the current busy bit for raddr[r], forced to 0 if an enabled write matches raddr[r] this cycle (the data is bypassed). A same-cycle rsv_en to raddr[r] does not affect rbusy until the next cycle.
- No internal state beyond the storage array and busy vector. No stalls and no handshake; every input is sampled every cycle.
- Address widths are exact. Every address in 0..REG_NUM-1 is legal, so there is no out-of-range case.

Decomposition:
- Shared package cpu_pkg (alongside existing word_t, regaddr_t, bit_t):
  - REG_NUM constant
  - regaddr_t sized $clog2(REG_NUM)
  - word_t sized DATA_W
- Sub-module regfile_sb: the busy-bit scoreboard, with set/clear/flush precedence and the per-read-port rbusy lookup.
- Storage, write-priority select and bypass mux stay in regfile_mp.

Test Plan:
- Reset, then read all 32 registers on both ports -> rdata=0 and rbusy=0 everywhere. Write r5=0xDEADBEEF, next cycle read r5 -> 0xDEADBEEF.
- Same cycle: NUM_WR=2, port0 writes r7=0x11111111, port1 writes r7=0x22222222, raddr[0]=7 -> rdata[0]=0x22222222 that cycle (bypass); stored 0x22222222 next cycle.
- ZERO_REG=1: we=1, waddr=0, wdata=0xFFFFFFFF, rsv_en to 0 -> rdata for r0 = 0 both in the same cycle and after; rbusy=0.
- rsv_en r3 at cycle t -> rbusy=1 for r3 at t+1. Write r3=0x5 at t+3 -> rbusy=0 and rdata=0x5 in cycle t+3, busy stays 0 at t+4.
- Reserve r9 and write r9=0xA in the same cycle -> rdata=0xA, and rbusy for r9 is 1 in the next cycle (set wins).
- Reserve r4 and r6 in successive cycles, then flush together with rsv_en r8 -> next cycle rbusy=0 for r4, r6 and r8. Assert rst mid-sequence after writing r10=0x3 -> r10 reads 0.
